// File: rtl/control_sequencer_if.sv
//------------------------------------------------------------------------------
// control_sequencer_if : control-word fields in, sequencer state/flags out.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface control_sequencer_if #(
  parameter int SW = 8
);
  logic [SW-1:0] enc_state;
  logic [SW-1:0] cr_addr;
  logic [2:0]    ns_sel;
  logic          cond_pass;
  logic          cond_in;
  logic          cond_inv;
  logic          moc;
  logic [SW-1:0] state;
  logic [SW-1:0] ret_state;
  logic          stall;
  logic          undef;
  logic          abort;

  modport master (
    output enc_state, cr_addr, ns_sel, cond_pass, cond_in, cond_inv, moc,
    input  state, ret_state, stall, undef, abort
  );

  modport slave (
    input  enc_state, cr_addr, ns_sel, cond_pass, cond_in, cond_inv, moc,
    output state, ret_state, stall, undef, abort
  );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer : microprogram next-state sequencer with MOC wait/timeout,
// conditional skip, undefined-opcode trap and one-deep call/return.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer #(
  parameter int SW          = 8,
  parameter int RESET_STATE = 0,
  parameter int FETCH_STATE = 1,
  parameter int UNDEF_STATE = 2,
  parameter int ABORT_STATE = 3,
  parameter int MOC_TIMEOUT = 15
) (
  input  wire logic          clk,
  input  wire logic          reset,
  control_sequencer_if.slave bus
);

  localparam logic [SW-1:0] c_reset_state = SW'(RESET_STATE);
  localparam logic [SW-1:0] c_fetch_state = SW'(FETCH_STATE);
  localparam logic [SW-1:0] c_undef_state = SW'(UNDEF_STATE);
  localparam logic [SW-1:0] c_abort_state = SW'(ABORT_STATE);
  localparam logic [7:0]    c_moc_timeout = 8'(MOC_TIMEOUT);

  localparam logic [2:0] c_ns_decode  = 3'd0;
  localparam logic [2:0] c_ns_inc     = 3'd1;
  localparam logic [2:0] c_ns_jump    = 3'd2;
  localparam logic [2:0] c_ns_waitmoc = 3'd3;
  localparam logic [2:0] c_ns_cjump   = 3'd4;
  localparam logic [2:0] c_ns_call    = 3'd5;
  localparam logic [2:0] c_ns_return  = 3'd6;
  localparam logic [2:0] c_ns_refetch = 3'd7;

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] ret_q, ret_d;
  logic [7:0]    wait_q, wait_d;
  logic          undef_q, undef_d;
  logic          abort_q, abort_d;
  logic          stall_w;
  logic [SW-1:0] inc_w;

  assign inc_w = state_q + SW'(1);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    wait_d  = '0;
    undef_d = 1'b0;
    abort_d = 1'b0;
    stall_w = 1'b0;
    case (bus.ns_sel)
      c_ns_decode: begin
        // A failed condition skips the instruction before the opcode is judged.
        if (!bus.cond_pass) begin
          state_d = c_fetch_state;
        end else if (bus.enc_state == '0) begin
          state_d = c_undef_state;
          undef_d = 1'b1;
        end else begin
          state_d = bus.enc_state;
        end
      end
      c_ns_inc:  state_d = inc_w;
      c_ns_jump: state_d = bus.cr_addr;
      c_ns_waitmoc: begin
        if (bus.moc) begin
          state_d = inc_w;
        end else if (wait_q < c_moc_timeout) begin
          stall_w = 1'b1;
          wait_d  = wait_q + 8'd1;
        end else begin
          state_d = c_abort_state;
          abort_d = 1'b1;
        end
      end
      c_ns_cjump:   state_d = (bus.cond_in ^ bus.cond_inv) ? bus.cr_addr : inc_w;
      c_ns_call: begin
        ret_d   = inc_w;
        state_d = bus.cr_addr;
      end
      c_ns_return:  state_d = ret_q;
      c_ns_refetch: state_d = c_fetch_state;
      default:      state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_reset_state;
      ret_q   <= '0;
      wait_q  <= '0;
      undef_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      undef_q <= undef_d;
      abort_q <= abort_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.ret_state = ret_q;
  assign bus.stall     = stall_w;
  assign bus.undef     = undef_q;
  assign bus.abort     = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// tb_control_sequencer : directed + randomized scoreboard bench.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  localparam int SW      = 8;
  localparam int FETCH   = 1;
  localparam int UNDEF   = 2;
  localparam int ABORT   = 3;
  localparam int TIMEOUT = 15;

  typedef struct {
    int st;
    int ret;
    bit stall;
    bit undef;
    bit abort;
  } exp_t;

  logic clk;
  logic reset;
  control_sequencer_if #(.SW(SW)) bus ();

  control_sequencer #(
    .SW(SW), .RESET_STATE(0), .FETCH_STATE(FETCH), .UNDEF_STATE(UNDEF),
    .ABORT_STATE(ABORT), .MOC_TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain integer state, independent of the RTL's encoding.
  int m_state = 0;
  int m_ret   = 0;
  int m_wait  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input int ns, input int enc, input int cr, input bit cp,
                      input bit ci, input bit cinv, input bit mo);
    exp_t e;
    int   inc, n, nr, nw;
    @(negedge clk);
    #1;
    bus.ns_sel    = 3'(ns);
    bus.enc_state = 8'(enc);
    bus.cr_addr   = 8'(cr);
    bus.cond_pass = cp;
    bus.cond_in   = ci;
    bus.cond_inv  = cinv;
    bus.moc       = mo;
    inc = (m_state + 1) % 256;
    n = m_state; nr = m_ret; nw = 0;
    e.stall = 0; e.undef = 0; e.abort = 0;
    case (ns)
      0: begin
        if (!cp) n = FETCH;
        else if (enc == 0) begin n = UNDEF; e.undef = 1; end
        else n = enc;
      end
      1: n = inc;
      2: n = cr;
      3: begin
        if (mo) n = inc;
        else if (m_wait < TIMEOUT) begin e.stall = 1; nw = m_wait + 1; end
        else begin n = ABORT; e.abort = 1; end
      end
      4: n = ((ci ^ cinv) != 0) ? cr : inc;
      5: begin nr = inc; n = cr; end
      6: n = m_ret;
      default: n = FETCH;
    endcase
    e.st = n; e.ret = nr;
    q.push_back(e);
    m_state = n; m_ret = nr; m_wait = nw;
  endtask

  // Monitor: stall is checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q[0];
        chk("stall", int'(bus.stall), int'(e.stall));
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("state", int'(bus.state), e.st);
        chk("ret_state", int'(bus.ret_state), e.ret);
        chk("undef", int'(bus.undef), int'(e.undef));
        chk("abort", int'(bus.abort), int'(e.abort));
      end
    end
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_ret"}, int'(bus.ret_state), 0);
    chk({tag, "_undef"}, int'(bus.undef), 0);
    chk({tag, "_abort"}, int'(bus.abort), 0);
  endtask

  initial begin
    int len;
    reset = 1'b0;
    bus.ns_sel = 3'd0; bus.enc_state = '0; bus.cr_addr = '0;
    bus.cond_pass = 1'b0; bus.cond_in = 1'b0; bus.cond_inv = 1'b0; bus.moc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    reset = 1'b1;

    // Fetch then decode ADD
    step(7, 0, 0, 0, 0, 0, 0);
    step(0, 5, 0, 1, 0, 0, 0);
    // Increment and wrap
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(2, 0, 255, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Conditional skip and undefined trap
    step(0, 12, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Call / return / conditional jump
    step(2, 0, 20, 0, 0, 0, 0);
    step(5, 0, 40, 0, 0, 0, 0);
    step(6, 0, 0, 0, 0, 0, 0);
    step(4, 0, 99, 0, 1, 1, 0);
    step(4, 0, 99, 0, 1, 0, 0);
    // MOC wait with late completion, then a second wait from zero
    step(2, 0, 31, 0, 0, 0, 0);
    repeat (4) step(3, 0, 0, 0, 0, 0, 0);
    step(3, 0, 0, 0, 0, 0, 1);
    repeat (2) step(3, 0, 0, 0, 0, 0, 0);
    step(3, 0, 0, 0, 0, 0, 1);
    // Full timeout to abort
    step(2, 0, 60, 0, 0, 0, 0);
    repeat (16) step(3, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // moc on the timeout cycle wins
    step(2, 0, 50, 0, 0, 0, 0);
    repeat (15) step(3, 0, 0, 0, 0, 0, 0);
    step(3, 0, 0, 0, 0, 0, 1);
    // Reset mid-wait
    step(2, 0, 70, 0, 0, 0, 0);
    repeat (7) step(3, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    reset_checks("async_reset");
    repeat (20) begin
      @(negedge clk);
      chk("abort_in_reset", int'(bus.abort), 0);
    end
    m_state = 0; m_ret = 0; m_wait = 0;
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic with occasional long wait bursts
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        len = $urandom_range(10, 20);
        for (int k = 0; k < len; k++)
          step(3, 0, 0, 0, 0, 0, $urandom_range(0, 24) == 0);
      end else begin
        step($urandom_range(0, 7),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
             $urandom_range(0, 255),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0);
      end
    end

    len = 0;
    while (q.size() > 0 && len < 10) begin
      @(posedge clk);
      len++;
    end
    #3;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
